// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator for a VGA-style display (1024x768 at default
// parameters). The module produces pixel/line counters together with sync,
// blanking and frame-start flags. Every output is registered in the same
// process, so the flags always decode the counts shown in the same cycle.
//
// Configuration macro:
//   VGA_TIMING_NEG_SYNC_EN - when defined, hsync/vsync are active-low (idle
//                            high, including during reset). When undefined,
//                            they are active-high (idle low).
//
// Ports:
//   clk         in   pixel clock, rising edge
//   reset       in   asynchronous active-high reset
//   pix_en      in   pixel advance enable; outputs hold while low
//   hcount      out  [11:0] current column, 0..H_TOTAL-1
//   hsync       out  horizontal sync
//   hblnk       out  high outside the visible columns
//   vcount      out  [11:0] current line, 0..V_TOTAL-1
//   vsync       out  vertical sync
//   vblnk       out  high outside the visible lines
//   frame_start out  one-cycle pulse when (0,0) follows the end of a frame
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   output logic [11:0] hcount,
   output logic        hsync,
   output logic        hblnk,
   output logic [11:0] vcount,
   output logic        vsync,
   output logic        vblnk,
   output logic        frame_start
);

   localparam logic [11:0] H_TOTAL   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam logic [11:0] V_TOTAL   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [11:0] H_VIS     = 12'(H_ACTIVE);
   localparam logic [11:0] V_VIS     = 12'(V_ACTIVE);
   localparam logic [11:0] HS_BEGIN  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_BEGIN  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_TIMING_NEG_SYNC_EN
   localparam logic SYNC_ON = 1'b0;
`else
   localparam logic SYNC_ON = 1'b1;
`endif
   localparam logic SYNC_OFF = ~SYNC_ON;

   logic [11:0] h_next_s;
   logic [11:0] v_next_s;
   logic        h_wrap_s;
   logic        frame_next_s;
   logic        hsync_next_s;
   logic        hblnk_next_s;
   logic        vsync_next_s;
   logic        vblnk_next_s;

   // Next counter values; the flags are decoded from these next values so the
   // registered flags line up with the registered counts with zero skew.
   always_comb begin
      h_next_s     = 12'd0;
      v_next_s     = vcount;
      h_wrap_s     = 1'b0;
      frame_next_s = 1'b0;
      if (hcount == (H_TOTAL - 12'd1)) begin
         h_wrap_s = 1'b1;
         h_next_s = 12'd0;
      end else begin
         h_next_s = hcount + 12'd1;
      end
      if (h_wrap_s) begin
         if (vcount == (V_TOTAL - 12'd1)) begin
            v_next_s     = 12'd0;
            frame_next_s = 1'b1;
         end else begin
            v_next_s = vcount + 12'd1;
         end
      end else begin
         v_next_s = vcount;
      end
   end

   // Sync and blank decode of the next position.
   always_comb begin
      hblnk_next_s = (h_next_s >= H_VIS);
      vblnk_next_s = (v_next_s >= V_VIS);
      if ((h_next_s >= HS_BEGIN) && (h_next_s < HS_END)) begin
         hsync_next_s = SYNC_ON;
      end else begin
         hsync_next_s = SYNC_OFF;
      end
      if ((v_next_s >= VS_BEGIN) && (v_next_s < VS_END)) begin
         vsync_next_s = SYNC_ON;
      end else begin
         vsync_next_s = SYNC_OFF;
      end
   end

   // Output registers: everything advances together on an enabled edge.
   // A stalled edge holds the position but clears frame_start so the pulse
   // lasts exactly one enabled cycle. The reset state has no frame_start,
   // so (0,0) out of reset never pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount      <= 12'd0;
         vcount      <= 12'd0;
         hsync       <= SYNC_OFF;
         vsync       <= SYNC_OFF;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         frame_start <= 1'b0;
      end else if (pix_en) begin
         hcount      <= h_next_s;
         vcount      <= v_next_s;
         hsync       <= hsync_next_s;
         vsync       <= vsync_next_s;
         hblnk       <= hblnk_next_s;
         vblnk       <= vblnk_next_s;
         frame_start <= frame_next_s;
      end else begin
         frame_start <= 1'b0;
      end
   end

endmodule
